mux_sel_scanner: RTL

//   Round-robin selection stage driving the S1/S0 select pair of the 4:1 data multiplexer.

---
 rtl/mux_sel_scanner.sv | 104 ++++++++++
 1 files changed

// File: rtl/mux_sel_scanner.sv
// Round-robin select generator for the S1/S0 pair of a 4:1 data mux.
// One request channel at a time is granted for a programmable dwell.
module mux_sel_scanner #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [3:0]         req,
    input  logic [DWELL_W-1:0] dwell,
    output logic               S0,
    output logic               S1,
    output logic [3:0]         grant,
    output logic               valid,
    output logic               switch_pulse
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t             state;
    logic [1:0]         sel;
    logic [1:0]         ptr;
    logic [DWELL_W-1:0] count;

    logic               found;
    logic [1:0]         winner;
    logic [1:0]         idx;
    logic [DWELL_W-1:0] load_count;
    logic               release_now;

    // The select lines come straight from a register, so the mux never sees glitches.
    assign {S1, S0} = sel;

    // Rotating priority search starting at ptr; the last owner sits at the end.
    always_comb begin
        found  = 1'b0;
        winner = ptr;
        idx    = ptr;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign load_count  = (dwell == '0) ? DWELL_W'(1) : dwell;
    assign release_now = (count == DWELL_W'(1)) || !req[sel] || !enable;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            sel          <= 2'd0;
            ptr          <= 2'd0;
            count        <= '0;
            grant        <= 4'b0000;
            valid        <= 1'b0;
            switch_pulse <= 1'b0;
        end else begin
            switch_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable && found) begin
                        state        <= HOLD;
                        sel          <= winner;
                        ptr          <= winner + 2'd1;
                        count        <= load_count;
                        grant        <= 4'b0001 << winner;
                        valid        <= 1'b1;
                        switch_pulse <= 1'b1;
                    end
                end
                HOLD: begin
                    count <= count - DWELL_W'(1);
                    if (release_now) begin
                        // Hand over without an idle cycle when anyone is still asking.
                        if (enable && found) begin
                            sel          <= winner;
                            ptr          <= winner + 2'd1;
                            count        <= load_count;
                            grant        <= 4'b0001 << winner;
                            valid        <= 1'b1;
                            switch_pulse <= 1'b1;
                        end else begin
                            state <= IDLE;
                            grant <= 4'b0000;
                            valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 4'b0000;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
